adsr_envelope_gen: RTL
======================

Name: adsr_envelope_gen

Overview:
- Parametrised ADSR envelope generator; successor to the fixed 8-bit ADSR used by the PWM/UART signal generator.
- Width, time base and rate resolution are generic.
- Adds gate-edge detection, legato retrigger from the current level, a deterministic rate prescaler, and stage/done status.
- Sits between the control decoder (UART/ADC-derived rates and gate) and the PWM comparator. `envelope` scales or replaces the wavetable sample.

Parameters:
- ENV_W, 8: envelope width; full scale ENV_MAX = 2^ENV_W-1.
- RATE_W, 8: width of each rate input.
- PRESCALE, 256: clk cycles per tick (>=1). Sets the time base.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- gate  in  1  note gate; level-sensitive, synchronous to clk.
- attack_rate  in  RATE_W  ticks per attack step, minus 1.
- decay_rate  in  RATE_W  ticks per decay step, minus 1.
- sustain_level  in  ENV_W  sustain target.
- release_rate  in  RATE_W  ticks per release step, minus 1.
- envelope  out  ENV_W  current envelope value, registered.
- stage  out  3  current stage encoding (package enum).
- active  out  1  high whenever stage != IDLE.
- done  out  1  one-cycle pulse when RELEASE reaches 0.

Behaviour:
- Reset (async, any time including mid-stage) forces:
  - stage = IDLE, envelope = 0, done = 0;
  - prescaler, step counter and gate_q = 0.
- Edge detection: gate_q registers gate.
  - rise = gate & ~gate_q; fall = ~gate & gate_q.
  - The stage changes on the clk edge where rise/fall is seen, i.e. one cycle after the gate pin changes.
- Time base:
  - prescaler counts 0..PRESCALE-1; tick is asserted when it equals PRESCALE-1.
  - step counter counts ticks 0..rate; a step fires on a tick with step_cnt == rate.
  - One step therefore takes (rate+1)*PRESCALE cycles.
  - Both counters clear on every stage entry, so the first step is deterministic.
  - Rates are sampled live: a change mid-stage affects the next compare.
- Stages and transitions (first match wins):
  - IDLE: envelope held 0. rise -> ATTACK.
  - ATTACK: each step envelope += 1.
    - When envelope == ENV_MAX, go to DECAY in the same cycle; no overshoot or wrap.
    - fall -> RELEASE.
  - DECAY: each step envelope -= 1.
    - When envelope <= sustain_level, go to SUSTAIN and load envelope = sustain_level.
    - If sustain_level >= envelope on entry, go to SUSTAIN next cycle.
    - fall -> RELEASE.
  - SUSTAIN: envelope = sustain_level every cycle (tracks live changes). fall -> RELEASE.
  - RELEASE: each step envelope -= 1.
    - When envelope == 0, go to IDLE and pulse done for 1 cycle.
    - rise -> ATTACK.
- Retrigger (rise in RELEASE, or rise after a short gate drop):
  - ATTACK restarts from the current envelope; no jump to 0 (legato).
  - A rise seen in ATTACK/DECAY/SUSTAIN also re-enters ATTACK from the current value.
- Simultaneous events: rise/fall take priority over a step in the same cycle. A step and a stage change never both apply.
- Arithmetic: envelope saturates at 0 and ENV_MAX; no wrap-around under any rate or level.
- envelope updates only on a step, a stage load, or reset. Output latency is 0 cycles from the internal register.
- active and stage are registered with the state. done is registered.

Decomposition:
- Package adsr_pkg:
  - stage enum IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4 (3-bit);
  - helper function env_max(ENV_W).
- One sub-module, adsr_rate_timer: prescaler plus step counter.
  - Inputs: clk, rst, clear, rate. Output: step pulse.
  - Reused by future LFO/sweep blocks.
- FSM and datapath stay in adsr_envelope_gen.

Test Plan (PRESCALE=4, ENV_W=8, RATE_W=8):
- Reset mid-ATTACK (envelope ~100), rst pulsed 1 cycle -> envelope=0, stage=IDLE, done=0 immediately (async), no step for >=4 cycles after release of rst.
- Attack timing: attack_rate=0, gate rises -> stage=ATTACK 1 cycle later; envelope 0->255 in 255 steps of 4 cycles = 1020 cycles, then DECAY, no 0 wrap.
- Decay/sustain: decay_rate=1, sustain_level=200 -> 55 steps of 8 cycles to 200, then SUSTAIN; change sustain_level to 180 -> envelope=180 next cycle.
- Release/done: gate falls in SUSTAIN at 180, release_rate=0 -> 180 steps x 4 cycles, envelope=0, one-cycle done, stage=IDLE, active=0.
- Legato retrigger: gate falls at 255, rises when envelope=120 in RELEASE -> ATTACK resumes from 120, reaches 255 after 135 steps.
- Edge cases: sustain_level=255 -> DECAY exits to SUSTAIN in 1 cycle; gate high through a 1-cycle drop (fall then rise) -> RELEASE for 1 cycle, then ATTACK from the held value.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared types and helpers for the ADSR envelope generator and related modulators.
package adsr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_stage_e;

  function automatic int unsigned env_max(input int unsigned env_w);
    return (32'd1 << env_w) - 32'd1;
  endfunction

endpackage

// File: rtl/adsr_envelope_gen_if.sv
// Control/status bundle between the control decoder, the envelope generator and the PWM path.
interface adsr_envelope_gen_if import adsr_pkg::*; #(
  parameter int unsigned ENV_W  = 8,
  parameter int unsigned RATE_W = 8
);

  logic              gate;
  logic [RATE_W-1:0] attack_rate;
  logic [RATE_W-1:0] decay_rate;
  logic [RATE_W-1:0] release_rate;
  logic [ENV_W-1:0]  sustain_level;
  logic [ENV_W-1:0]  envelope;
  adsr_stage_e       stage;
  logic              active;
  logic              done;

  modport master (
    output gate, attack_rate, decay_rate, release_rate, sustain_level,
    input  envelope, stage, active, done
  );

  modport slave (
    input  gate, attack_rate, decay_rate, release_rate, sustain_level,
    output envelope, stage, active, done
  );

endinterface

// File: rtl/adsr_rate_timer.sv
// Prescaled step timer: one step pulse every (rate+1)*PRESCALE cycles after a clear.
module adsr_rate_timer #(
  parameter int unsigned RATE_W   = 8,
  parameter int unsigned PRESCALE = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  output logic              step
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]   presc_q, presc_d;
  logic [RATE_W-1:0] step_cnt_q, step_cnt_d;
  logic              tick;
  logic              step_hit;

  // A rate lowered below the running count steps on the next tick instead of wrapping.
  always_comb begin
    tick     = (presc_q == PS_LAST);
    step_hit = tick && (step_cnt_q >= rate);
  end

  always_comb begin
    presc_d    = presc_q;
    step_cnt_d = step_cnt_q;
    if (clear) begin
      presc_d    = '0;
      step_cnt_d = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        step_cnt_d = step_hit ? '0 : step_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      step_cnt_q <= '0;
    end else begin
      presc_q    <= presc_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign step = step_hit;

endmodule

// File: rtl/adsr_envelope_gen.sv
// ADSR envelope generator: gate-edge driven FSM with legato retrigger and saturating datapath.
module adsr_envelope_gen import adsr_pkg::*; #(
  parameter int unsigned ENV_W    = 8,
  parameter int unsigned RATE_W   = 8,
  parameter int unsigned PRESCALE = 256
) (
  input logic               clk,
  input logic               rst,
  adsr_envelope_gen_if.slave bus
);

  localparam logic [ENV_W-1:0] ENV_MAX  = ENV_W'(env_max(ENV_W));
  localparam logic [ENV_W-1:0] ENV_NEAR = ENV_MAX - 1'b1;

  adsr_stage_e       stage_q, stage_d;
  logic [ENV_W-1:0]  env_q, env_d;
  logic [ENV_W-1:0]  env_dec;
  logic              done_q, done_d;
  logic              gate_q;
  logic              rise, fall;
  logic              enter;
  logic              step;
  logic [RATE_W-1:0] rate_sel;

  assign rise    = bus.gate & ~gate_q;
  assign fall    = ~bus.gate & gate_q;
  assign env_dec = env_q - 1'b1;

  always_comb begin
    case (stage_q)
      ATTACK:  rate_sel = bus.attack_rate;
      DECAY:   rate_sel = bus.decay_rate;
      RELEASE: rate_sel = bus.release_rate;
      default: rate_sel = '0;
    endcase
  end

  adsr_rate_timer #(
    .RATE_W  (RATE_W),
    .PRESCALE(PRESCALE)
  ) u_rate_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(enter),
    .rate (rate_sel),
    .step (step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= IDLE;
      env_q   <= '0;
      done_q  <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      env_q   <= env_d;
      done_q  <= done_d;
      gate_q  <= bus.gate;
    end
  end

  // Gate edges outrank steps; every taken transition (re-entry included) restarts the timer.
  always_comb begin
    stage_d = stage_q;
    env_d   = env_q;
    done_d  = 1'b0;
    enter   = 1'b0;
    case (stage_q)
      IDLE: begin
        if (rise) begin
          stage_d = ATTACK;
          enter   = 1'b1;
        end
      end
      ATTACK: begin
        if (fall) begin
          stage_d = RELEASE;
          enter   = 1'b1;
        end else if (rise) begin
          enter = 1'b1;
        end else if (env_q == ENV_MAX) begin
          stage_d = DECAY;
          enter   = 1'b1;
        end else if (step) begin
          env_d = env_q + 1'b1;
          if (env_q == ENV_NEAR) begin
            stage_d = DECAY;
            enter   = 1'b1;
          end
        end
      end
      DECAY: begin
        if (fall) begin
          stage_d = RELEASE;
          enter   = 1'b1;
        end else if (rise) begin
          stage_d = ATTACK;
          enter   = 1'b1;
        end else if (env_q <= bus.sustain_level) begin
          stage_d = SUSTAIN;
          env_d   = bus.sustain_level;
          enter   = 1'b1;
        end else if (step) begin
          env_d = env_dec;
          if (env_dec <= bus.sustain_level) begin
            stage_d = SUSTAIN;
            env_d   = bus.sustain_level;
            enter   = 1'b1;
          end
        end
      end
      SUSTAIN: begin
        if (fall) begin
          stage_d = RELEASE;
          enter   = 1'b1;
        end else if (rise) begin
          stage_d = ATTACK;
          enter   = 1'b1;
        end else begin
          env_d = bus.sustain_level;
        end
      end
      RELEASE: begin
        if (rise) begin
          stage_d = ATTACK;
          enter   = 1'b1;
        end else if (env_q == '0) begin
          stage_d = IDLE;
          done_d  = 1'b1;
          enter   = 1'b1;
        end else if (step) begin
          env_d = env_dec;
          if (env_dec == '0) begin
            stage_d = IDLE;
            done_d  = 1'b1;
            enter   = 1'b1;
          end
        end
      end
      default: begin
        stage_d = IDLE;
        env_d   = '0;
        enter   = 1'b1;
      end
    endcase
  end

  always_comb begin
    bus.envelope = env_q;
    bus.stage    = stage_q;
    bus.active   = (stage_q != IDLE);
    bus.done     = done_q;
  end

endmodule
